sccb_responder: RTL
===================

// Module: sccb_responder
// PURPOSE
//  Camera-side (target) end of the SCCB bus driven by the camera register-config initiator. Accepts
//  3-phase writes and 2-phase reads, and holds a 256x8 register file. Each completed write is
//  reported as one {sub_addr,data} word, the same 16-bit format as the config ROM entries.
//  Used as an OV7670 stand-in for simulation and on-board loopback checks of the config path.
// PARAMETERS
//  DEV_ID       7'h21  7-bit device ID (0x42 write / 0x43 read on the wire)
//  SYNC_STAGES  2      synchroniser flops on sioc/siod_in (>=2)
// PORTS
//  clk           in   1   system clock; must be >= 8x SIOC frequency
//  rst           in   1   asynchronous, active-high reset
//  sioc          in   1   SCCB clock from initiator (async)
//  siod_in       in   1   SCCB data, sampled from bus (async)
//  siod_out      out  1   value driven on SIOD when siod_oe=1
//  siod_oe       out  1   1 = responder drives SIOD
//  wr_valid      out  1   1-cycle pulse: register write committed
//  wr_addr_data  out  16  {sub_addr[7:0], data[7:0]} of last commit; held until next commit
//  soft_reset    out  1   1-cycle pulse when reg 0x12 written with bit7=1
//  peek_addr     in   8   debug read address into the register file
//  peek_data     out  8   regfile[peek_addr], registered (1-cycle latency)
// BEHAVIOUR
//  Reset: all outputs 0, regfile all 0x00, sub_addr=0, state IDLE. Reset mid-transfer aborts it
//   with no commit and releases SIOD in the same cycle.
//  Sampling: sioc/siod_in pass through SYNC_STAGES flops plus one history flop.
//   START = SIOD falls while SIOC=1. STOP = SIOD rises while SIOC=1.
//   Bits shift in MSB-first on the SIOC rising edge and are driven on the SIOC falling edge.
//  START in any state -> ID with bit counter 0 (repeated start allowed). STOP in any state -> IDLE
//   and siod_oe=0. If START/STOP and an SIOC edge are detected in the same cycle, START/STOP wins.
//  FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP.
//   ID: after 8 bits, compare [7:1] to DEV_ID. Match -> ID_ACK. Mismatch -> WAIT_STOP, never drive.
//   x_ACK (9th "don't-care" bit): siod_oe=1 and siod_out=0, from the falling edge after bit 8 to
//    the next falling edge. After ID_ACK: R/W=0 -> SUB, R/W=1 -> RDATA.
//   SUB: 8 bits -> sub_addr. After SUB_ACK -> WDATA.
//   WDATA: 8 bits. On the cycle after the 8th rising edge is detected, do all of the following:
//    regfile[sub_addr]<=data, wr_valid=1, wr_addr_data={sub_addr,data}; also soft_reset=1 if
//    sub_addr==8'h12 and data[7]=1. Then WDATA_ACK -> WAIT_STOP: extra bytes get no ACK and are
//    not written. soft_reset does NOT clear the regfile.
//   RDATA: drive regfile[sub_addr] MSB-first; siod_oe=1 through bit 8's high phase.
//    RD_NA: release SIOD and ignore the NA bit -> WAIT_STOP.
//  2-phase write (ID,SUB,STOP) updates sub_addr only. No auto-increment of sub_addr.
//  STOP inside WDATA before bit 8: no commit. The regfile write and peek read are in the same
//   cycle on one address: peek_data returns the old value that cycle and the new value after.
// STRUCTURE
//  sccb_pkg: state enum/localparams, SCCB_COM7_ADDR=8'h12, SCCB_SOFT_RST_BIT=7, and the
//   16'hFFFF end / 16'hFFF0 delay markers shared with the config ROM and the initiator.
//  Sub-module sccb_line_sync: synchroniser plus edge/START/STOP detector (one per bus).
//  Top holds the FSM, shift register, bit counter and regfile.
// TESTING
//  1 Write ID 0x42, sub 0x11, data 0x85, STOP -> wr_valid once, wr_addr_data=16'h1185;
//    ACK low in all 3 ACK slots; peek 0x11 = 0x85.
//  2 Write 0x12_80 -> soft_reset pulses once, wr_addr_data=16'h1280; peek 0x11 still 0x85.
//  3 ID 0x60 + 2 bytes + STOP -> siod_oe stays 0, no wr_valid, regfile unchanged.
//  4 2-phase write sub 0x11, STOP, then 2-phase read ID 0x43 -> bits 1000_0101 seen on rising
//    SIOC edges, SIOD released at NA bit.
//  5 Write 0x3A, START mid-WDATA (bit 5), then full write 0x3A_04 -> exactly one commit, 16'h3A04.
//  6 Assert rst during the sub-address ACK -> siod_oe=0 next cycle, peek(any)=0x00; next full
//    write succeeds.
//  Also replay the full config ROM through the real initiator (delay entries excluded) ->
//    the wr_addr_data sequence equals the ROM sequence.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder FSM states, register constants and the
// config ROM end/delay markers used by the ROM, the initiator and the responder.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_NA,
    ST_WAIT_STOP
  } sccb_state_e;

  localparam logic [7:0]  SCCB_COM7_ADDR     = 8'h12;
  localparam int unsigned SCCB_SOFT_RST_BIT  = 7;
  localparam logic [3:0]  SCCB_BITS_PER_BYTE = 4'd8;

  localparam logic [15:0] SCCB_END_MARKER    = 16'hFFFF;
  localparam logic [15:0] SCCB_DELAY_MARKER  = 16'hFFF0;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises SIOC/SIOD into the clk domain and detects SIOC edges plus
// START/STOP conditions from the synchronised levels and a one-flop history.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sioc,
  input  logic siod,
  output logic siod_lvl,
  output logic sioc_rise,
  output logic sioc_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
  logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
  logic                   sioc_hist_q, sioc_hist_d;
  logic                   siod_hist_q, siod_hist_d;
  logic                   sioc_lvl;

  always_comb begin
    sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], sioc};
    siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], siod};
    sioc_hist_d = sioc_sync_q[SYNC_STAGES-1];
    siod_hist_d = siod_sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-bus level so leaving reset never looks like a START/STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_hist_q <= 1'b1;
      siod_hist_q <= 1'b1;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      sioc_hist_q <= sioc_hist_d;
      siod_hist_q <= siod_hist_d;
    end
  end

  always_comb begin
    sioc_lvl  = sioc_sync_q[SYNC_STAGES-1];
    siod_lvl  = siod_sync_q[SYNC_STAGES-1];
    sioc_rise = sioc_lvl & ~sioc_hist_q;
    sioc_fall = ~sioc_lvl & sioc_hist_q;
    start     = sioc_lvl & sioc_hist_q & siod_hist_q & ~siod_lvl;
    stop      = sioc_lvl & sioc_hist_q & ~siod_hist_q & siod_lvl;
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB target (OV7670 stand-in): 3-phase writes, 2-phase reads, 256x8 register
// file, commit reporting as {sub_addr,data} and a COM7 soft-reset pulse.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID      = 7'h21,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sioc,
  input  logic        siod_in,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr_data,
  output logic        soft_reset,
  input  logic [7:0]  peek_addr,
  output logic [7:0]  peek_data
);

  logic siod_lvl, sioc_rise, sioc_fall, start, stop;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sioc     (sioc),
    .siod     (siod_in),
    .siod_lvl (siod_lvl),
    .sioc_rise(sioc_rise),
    .sioc_fall(sioc_fall),
    .start    (start),
    .stop     (stop)
  );

  sccb_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  sub_addr_q, sub_addr_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_data_q, wr_addr_data_d;
  logic        soft_reset_q, soft_reset_d;
  logic [7:0]  peek_data_q, peek_data_d;
  logic [7:0]  regfile_q [256];
  logic [7:0]  regfile_d [256];
  logic [7:0]  rx_byte;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    sub_addr_d     = sub_addr_q;
    wr_valid_d     = 1'b0;
    soft_reset_d   = 1'b0;
    wr_addr_data_d = wr_addr_data_q;
    peek_data_d    = regfile_q[peek_addr];
    rx_byte        = {shift_q[6:0], siod_lvl};

    if (start) begin
      state_d   = ST_ID;
      bit_cnt_d = '0;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_ID, ST_SUB, ST_WDATA: begin
          if (sioc_rise && bit_cnt_q < SCCB_BITS_PER_BYTE) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // The commit is registered, so it lands the cycle after the 8th rise.
            if (state_q == ST_WDATA && bit_cnt_q == SCCB_BITS_PER_BYTE - 4'd1) begin
              wr_valid_d     = 1'b1;
              wr_addr_data_d = {sub_addr_q, rx_byte};
              soft_reset_d   = (sub_addr_q == SCCB_COM7_ADDR) && rx_byte[SCCB_SOFT_RST_BIT];
            end
          end else if (sioc_fall && bit_cnt_q == SCCB_BITS_PER_BYTE) begin
            if (state_q == ST_ID) begin
              state_d = (shift_q[7:1] == DEV_ID) ? ST_ID_ACK : ST_WAIT_STOP;
            end else if (state_q == ST_SUB) begin
              sub_addr_d = shift_q;
              state_d    = ST_SUB_ACK;
            end else begin
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_ID_ACK: begin
          if (sioc_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              state_d = ST_RDATA;
              shift_d = regfile_q[sub_addr_q];
            end else begin
              state_d = ST_SUB;
            end
          end
        end
        ST_SUB_ACK: begin
          if (sioc_fall) begin
            state_d   = ST_WDATA;
            bit_cnt_d = '0;
          end
        end
        ST_WDATA_ACK: begin
          if (sioc_fall) state_d = ST_WAIT_STOP;
        end
        ST_RDATA: begin
          if (sioc_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (sioc_fall) begin
            if (bit_cnt_q == SCCB_BITS_PER_BYTE) state_d = ST_RD_NA;
            else if (bit_cnt_q != 4'd0) shift_d = {shift_q[6:0], 1'b0};
          end
        end
        ST_RD_NA: begin
          if (sioc_rise) state_d = ST_WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regfile_d = regfile_q;
    if (wr_valid_d) regfile_d[sub_addr_q] = wr_addr_data_d[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      sub_addr_q     <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_data_q <= '0;
      soft_reset_q   <= 1'b0;
      peek_data_q    <= '0;
      for (int unsigned i = 0; i < 256; i++) regfile_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      sub_addr_q     <= sub_addr_d;
      wr_valid_q     <= wr_valid_d;
      wr_addr_data_q <= wr_addr_data_d;
      soft_reset_q   <= soft_reset_d;
      peek_data_q    <= peek_data_d;
      regfile_q      <= regfile_d;
    end
  end

  // Drive decoded straight from state so an async reset releases SIOD at once.
  always_comb begin
    siod_oe      = state_q inside {ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK, ST_RDATA};
    siod_out     = (state_q == ST_RDATA) & shift_q[7];
    wr_valid     = wr_valid_q;
    wr_addr_data = wr_addr_data_q;
    soft_reset   = soft_reset_q;
    peek_data    = peek_data_q;
  end

endmodule
